// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and constants for the product BCD display
package multiplier_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int PROD_W     = 16;
   localparam int BCD_DIGITS = 5;
   localparam int BCD_W      = 4 * BCD_DIGITS;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

   // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - BCD digit to active-low 7-segment pattern (gfedcba)
module bcd_seg_decoder (
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
         endcase
      end
   end

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - signed product to BCD + 7-seg; PRODUCT_BCD_BLANK_EN blanks leading zeros
module product_bcd_display
   import multiplier_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Product,
   output logic        Busy,
   output logic        Done,
   output logic        Neg,
   output logic [19:0] Digits,
   output logic [6:0]  Hex0,
   output logic [6:0]  Hex1,
   output logic [6:0]  Hex2,
   output logic [6:0]  Hex3,
   output logic [6:0]  Hex4,
   output logic [6:0]  HexSign
);

`ifdef PRODUCT_BCD_BLANK_EN
   localparam logic [6:0] HEX_UPPER_RST = SEG_BLANK;
`else
   localparam logic [6:0] HEX_UPPER_RST = SEG_ZERO;
`endif

   state_t              state, state_nxt;
   logic [PROD_W-1:0]   prod_reg;
   logic [PROD_W-1:0]   mag;
   logic [BCD_W-1:0]    scratch;
   logic [BCD_W-1:0]    scratch_adj;
   logic [3:0]          cnt;
   logic                sign_r;
   logic [4:0]          blank;
   logic [6:0]          seg [BCD_DIGITS];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (Start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == 4'd15) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign Busy        = (state != S_IDLE);
   assign scratch_adj = bcd_adjust(scratch);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         prod_reg <= '0;
         mag      <= '0;
         scratch  <= '0;
         cnt      <= '0;
         sign_r   <= 1'b0;
         Digits   <= '0;
         Neg      <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Done <= (state == S_DONE);
         case (state)
            S_IDLE:  if (Start) prod_reg <= Product;
            S_LOAD: begin
               // 16'h8000 negates to itself, which reads correctly as 32768 unsigned
               mag     <= prod_reg[15] ? (~prod_reg + 16'd1) : prod_reg;
               sign_r  <= prod_reg[15];
               scratch <= '0;
               cnt     <= '0;
            end
            S_SHIFT: begin
               scratch <= {scratch_adj[BCD_W-2:0], mag[PROD_W-1]};
               mag     <= {mag[PROD_W-2:0], 1'b0};
               cnt     <= cnt + 4'd1;
            end
            S_DONE: begin
               Digits <= scratch;
               Neg    <= sign_r;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      blank = '0;
`ifdef PRODUCT_BCD_BLANK_EN
      blank[4] = (Digits[19:16] == 4'd0);
      blank[3] = blank[4] && (Digits[15:12] == 4'd0);
      blank[2] = blank[3] && (Digits[11:8] == 4'd0);
      blank[1] = blank[2] && (Digits[7:4] == 4'd0);
`endif
   end

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dec
      bcd_seg_decoder u_dec (
         .bcd   (Digits[4*g +: 4]),
         .blank (blank[g]),
         .seg   (seg[g])
      );
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Hex0    <= SEG_ZERO;
         Hex1    <= HEX_UPPER_RST;
         Hex2    <= HEX_UPPER_RST;
         Hex3    <= HEX_UPPER_RST;
         Hex4    <= HEX_UPPER_RST;
         HexSign <= SEG_BLANK;
      end else begin
         Hex0    <= seg[0];
         Hex1    <= seg[1];
         Hex2    <= seg[2];
         Hex3    <= seg[3];
         Hex4    <= seg[4];
         HexSign <= Neg ? SEG_MINUS : SEG_BLANK;
      end
   end

endmodule

// File: doc/product_bcd_display.md
PRODUCT_BCD_DISPLAY -- requirements
Module: product_bcd_display

Interface
REQ-001 SHALL have ports: Clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: Start  input  1  one-cycle pulse from the multiplier control unit: Product is valid.
REQ-004 SHALL have: Product  input  16  two's-complement product from the 8x8 signed multiplier ({A,B}).
REQ-005 SHALL have: Busy  output  1  conversion in progress.
REQ-006 SHALL have: Done  output  1  one-cycle pulse: Digits/Neg updated.
REQ-007 SHALL have: Neg  output  1  sign of the last converted Product.
REQ-008 SHALL have: Digits  output  20  five packed BCD digits of |Product|, [19:16] most significant.
REQ-009 SHALL have: Hex0..Hex4  output  7 each  active-low 7-seg patterns of digits 0 (LSD)..4.
REQ-010 SHALL have: HexSign  output  7  active-low: '-' (7'b0111111) if Neg, else blank (7'h7F).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; Busy=1 exactly in LOAD, SHIFT, DONE.
REQ-012 IDLE: Start=1 at an edge SHALL capture Product and move to LOAD; otherwise stay.
REQ-013 LOAD: SHALL form 16-bit unsigned magnitude (negate if Product[15]), latch sign, clear the 20-bit BCD scratch, clear shift counter; next state SHIFT.
REQ-014 SHIFT: each cycle SHALL add 3 to every scratch digit >=5, then shift {scratch, magnitude} left by one; after exactly 16 SHIFT cycles go to DONE.
REQ-015 DONE: SHALL register scratch into Digits and sign into Neg, assert Done for that one cycle, then return to IDLE.
REQ-016 Latency: Done SHALL be high in the cycle following the 18th rising edge after the edge sampling Start; Busy high for exactly 18 cycles.
REQ-017 Start while Busy=1 (including DONE) SHALL be ignored; no queueing.
REQ-018 Product=16'h8000 SHALL yield magnitude 32768, Neg=1; Product=0 SHALL yield Neg=0.
REQ-019 Digits and Neg SHALL hold their last values between conversions.
REQ-020 Hex0..Hex4 and HexSign SHALL be registered one cycle after Digits/Neg update.
REQ-021 BCD codes 10-15 on any segment decoder input SHALL display blank.

Reset
REQ-022 Reset SHALL force IDLE, Busy=0, Done=0, Neg=0, Digits=0, counter=0 asynchronously.
REQ-023 Hex outputs SHALL reset to the display of value 0 per REQ-025/026; HexSign to blank.
REQ-024 Reset mid-conversion SHALL abort with no Done pulse; next Start after release converts normally.

Configuration
REQ-025 With PRODUCT_BCD_BLANK_EN defined: leading-zero digits Hex4..Hex1 SHALL be blank (7'h7F); Hex0 never blanked.
REQ-026 Without PRODUCT_BCD_BLANK_EN: all five digits SHALL always be displayed, including leading zeros.

Structure
REQ-027 Shared package multiplier_pkg SHALL hold the FSM state enum, PROD_W=16, BCD_DIGITS=5, SEG_BLANK, SEG_MINUS constants.
REQ-028 One sub-module bcd_seg_decoder (4-bit BCD + blank -> 7-bit active-low segments) SHALL be instantiated five times.

Verification
REQ-029 Product=16'h4000 (-128*-128), Start pulse -> Done 18 edges later, Digits=20'h16384, Neg=0, Hex4..0 show 1,6,3,8,4.
REQ-030 Product=16'hC080 (-128*127) -> Digits=20'h16256, Neg=1, HexSign=7'b0111111.
REQ-031 Product=0 -> Digits=0, Neg=0; with PRODUCT_BCD_BLANK_EN Hex4..1=7'h7F, Hex0='0'; without, all '0'.
REQ-032 Product=16'h8000 -> Digits=20'h32768, Neg=1.
REQ-033 Start re-pulsed in SHIFT cycle 5 with different Product -> ignored; single Done, Busy contiguous 18 cycles, first Product's result.
REQ-034 Reset asserted in SHIFT cycle 10 -> Busy, Done, Digits, Neg to 0 without waiting for Clk; no Done; subsequent Start 16'h0001 -> Digits=20'h00001.
